opti_sos_out_buf: RTL and testbench
===================================

Name: opti_sos_out_buf

Overview:
Downstream stage of the IIR SOS cascade. It takes the final section's output (valid/data with no backpressure), applies a programmable Q2.22 output gain with round-half-up and saturation, and buffers results in a small FIFO. The FIFO presents a ready/valid stream to the consumer (DAC or stream interface). The SOS chain cannot stall, so overflow drops samples and is counted, never back-pressured.

Parameters:
DATA_W, 24, sample and gain width (two's complement)
GAIN_FRAC, 22, fractional bits of gain (0x400000 = 1.0)
DEPTH, 16, FIFO entries (power of two, ≥4)
CNT_W, 16, drop counter width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset. Synchronous, active-high, one clock, reset is synchronous and active-high
in_valid  in  1  sample strobe from last SOS (data_valid_out)
in_data  in  DATA_W  signed sample (data_out of last SOS)
gain  in  DATA_W  signed Q2.22 output gain. Quasi-static; sampled with in_data
out_valid  out  1  FIFO non-empty
out_data  out  DATA_W  head-of-FIFO sample
out_ready  in  1  consumer accepts when out_valid & out_ready
level  out  $clog2(DEPTH)+1  current FIFO occupancy
sat_sticky  out  1  set when any sample saturated
ovf_sticky  out  1  set when any sample dropped
drop_cnt  out  CNT_W  dropped-sample count, saturating at all-ones
flag_clr  in  1  clears sat_sticky, ovf_sticky, drop_cnt

Behaviour:
- Reset (rst=1 at edge): all pipeline valids=0, rd/wr pointers=0, level=0, out_valid=0, out_data=0, sat_sticky=0, ovf_sticky=0, drop_cnt=0. Reset mid-stream discards in-flight and buffered samples.
- Stage 1 (S1): on in_valid, register p = in_data*gain (2*DATA_W bits signed). v1 <= in_valid.
- Stage 2 (S2): r = (p + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC (arithmetic). Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Register result and v2. If clamped and v1, set sat_sticky.
- Write: v2 at cycle N+2 writes the FIFO at that edge. out_valid is visible at N+3, so latency is 3 cycles from in_valid to out_valid with an empty FIFO. No bypass.
- out_data = mem[rd_ptr], combinational from the registered pointer. It is stable while out_valid & !out_ready.
- Pop when out_valid & out_ready: rd_ptr++ (wraps mod DEPTH).
- Push when v2 & (level<DEPTH | pop): wr_ptr++ (wraps).
- Full and pop in the same cycle: the push is accepted and level is unchanged.
- Empty and push: no pop is possible that cycle.
- Drop when v2 & level==DEPTH & !pop: the sample is discarded, ovf_sticky<=1, drop_cnt increments, saturating at 2^CNT_W-1.
- level updates: +1 on push only, -1 on pop only, unchanged on both or neither.
- flag_clr has priority over a same-cycle set. A set event in the same cycle as flag_clr is lost, and drop_cnt becomes 0.
- in_valid may be asserted every cycle (full throughput). Gaps are allowed.

Decomposition:
- Shared constants include file: DATA_W, GAIN_FRAC, Q-format one (0x400000), saturation limits SAT_MAX/SAT_MIN. These are reused by the SOS stages and the coefficient loader.
- Sub-module opti_sync_fifo: synchronous FIFO with parameters DEPTH and DATA_W. It provides push, pop, full, empty and level, and uses the same clk/rst. Gain/round/saturate stays in the top module.

Test Plan:
- Unity gain: gain=0x400000, in_data=1000 at cycle 0 with out_ready=1 → out_valid=1 and out_data=1000 at cycle 3. No flags set.
- Round/saturate:
  - gain=0x200000 (0.5): in 3 → 2 and in -3 → -1.
  - gain=0x7FFFFF with in 0x7FFFFF → 0x7FFFFF, sat_sticky=1.
  - gain=0x7FFFFF with in 0x800000 → 0x800000.
- Overflow: out_ready=0, 20 back-to-back samples 1..20 → level=16, drop_cnt=4, ovf_sticky=1. Draining then yields 1..16 in order, then out_valid=0.
- Full with simultaneous push/pop: FIFO full, out_ready=1 and in_valid every cycle → level stays 16, drop_cnt unchanged, output order preserved.
- Flag clear: flag_clr pulsed in the same cycle as a drop → drop_cnt=0, ovf_sticky=0. The next drop gives drop_cnt=1.
- Reset mid-stream: rst asserted with level=5 and samples in S1/S2 → next cycle level=0, out_valid=0, flags 0. No stale sample appears after release.

Source files
------------

// File: rtl/opti_sos_out_buf_pkg.sv
// Shared constants for the SOS cascade: sample width, gain Q-format and
// saturation limits used by the SOS stages, coefficient loader and output buffer.
package opti_sos_out_buf_pkg;

    localparam int SOS_DATA_W    = 24;
    localparam int SOS_GAIN_FRAC = 22;

    // Q2.22 representation of 1.0
    localparam logic [SOS_DATA_W-1:0] SOS_Q_ONE   = 24'h400000;

    // Two's complement clamp limits for a SOS_DATA_W sample
    localparam logic [SOS_DATA_W-1:0] SOS_SAT_MAX = 24'h7FFFFF;
    localparam logic [SOS_DATA_W-1:0] SOS_SAT_MIN = 24'h800000;

endpackage

// File: rtl/opti_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Handshake contract: the owner asserts push only when !full or when pop is
// asserted in the same cycle, and asserts pop only when !empty. A push and a
// pop in the same cycle leave the level unchanged. dout shows the head entry
// whenever !empty and reads as zero when empty.
module opti_sync_fifo
    import opti_sos_out_buf_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = SOS_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;

    // Pointer, storage and occupancy updates; pointers wrap naturally mod DEPTH
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/opti_sos_out_buf.sv
// Output stage of the SOS cascade: Q2.22 gain, round-half-up, saturate, then
// buffer into a FIFO. The upstream chain cannot stall, so a full FIFO drops
// the incoming sample and counts it instead of applying backpressure.
// Consumer handshake: a sample transfers on a cycle where out_valid and
// out_ready are both high; out_data holds steady while out_valid & !out_ready.
module opti_sos_out_buf
    import opti_sos_out_buf_pkg::*;
#(
    parameter int DATA_W    = SOS_DATA_W,
    parameter int GAIN_FRAC = SOS_GAIN_FRAC,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [DATA_W-1:0]      gain,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   sat_sticky,
    output logic                   ovf_sticky,
    output logic [CNT_W-1:0]       drop_cnt,
    input  logic                   flag_clr
);

    localparam int PW = 2 * DATA_W;

    // Half an LSB of the result, added before the arithmetic shift
    localparam logic signed [PW-1:0] RND =
        {{(PW-GAIN_FRAC){1'b0}}, 1'b1, {(GAIN_FRAC-1){1'b0}}};
    // Clamp limits, sign-extended to product width for comparison
    localparam logic signed [PW-1:0] MAX_W =
        {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_W =
        {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [PW-1:0] in_ext, gain_ext;
    logic signed [PW-1:0] p_q, p_d;
    logic                 v1_q, v1_d;
    logic signed [PW-1:0] sum, shifted;
    logic                 clamp_hi, clamp_lo, sat_evt;
    logic [DATA_W-1:0]    res_q, res_d;
    logic                 v2_q, v2_d;
    logic                 sat_q, sat_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop, drop;

    assign in_ext   = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign gain_ext = {{DATA_W{gain[DATA_W-1]}}, gain};

    // S1: full-precision signed product, captured only on a valid sample
    always_comb begin
        v1_d = in_valid;
        p_d  = p_q;
        if (in_valid) begin
            p_d = in_ext * gain_ext;
        end
    end

    // S2: round half up, drop the fractional bits, clamp to sample range
    always_comb begin
        sum      = p_q + RND;
        shifted  = sum >>> GAIN_FRAC;
        clamp_hi = (shifted > MAX_W);
        clamp_lo = (shifted < MIN_W);
        sat_evt  = v1_q & (clamp_hi | clamp_lo);
        v2_d     = v1_q;
        res_d    = res_q;
        if (v1_q) begin
            if (clamp_hi)      res_d = SMAX;
            else if (clamp_lo) res_d = SMIN;
            else               res_d = shifted[DATA_W-1:0];
        end
    end

    // FIFO write/drop decision and sticky status; flag_clr beats any set
    always_comb begin
        pop    = ~fifo_empty & out_ready;
        push   = v2_q & (~fifo_full | pop);
        drop   = v2_q & fifo_full & ~pop;
        sat_d  = sat_q | sat_evt;
        ovf_d  = ovf_q | drop;
        drop_d = drop_q;
        if (drop && !(&drop_q)) begin
            drop_d = drop_q + CNT_W'(1);
        end
        if (flag_clr) begin
            sat_d  = 1'b0;
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    // Pipeline and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            p_q    <= '0;
            v2_q   <= 1'b0;
            res_q  <= '0;
            sat_q  <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            v1_q   <= v1_d;
            p_q    <= p_d;
            v2_q   <= v2_d;
            res_q  <= res_d;
            sat_q  <= sat_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    opti_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (res_q),
        .pop   (pop),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_valid  = ~fifo_empty;
    assign sat_sticky = sat_q;
    assign ovf_sticky = ovf_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_opti_sos_out_buf.sv
// Directed bench for opti_sos_out_buf: gain/round/saturate table plus
// overflow, full push/pop, flag clear and mid-stream reset sequences.
module tb_opti_sos_out_buf;
    import opti_sos_out_buf_pkg::*;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic [W-1:0]  gain;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [4:0]    level;
    logic          sat_sticky;
    logic          ovf_sticky;
    logic [15:0]   drop_cnt;
    logic          flag_clr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] gain;
        logic [W-1:0] din;
        logic [W-1:0] exp_out;
        logic         exp_sat;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    opti_sos_out_buf dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .gain       (gain),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .sat_sticky (sat_sticky),
        .ovf_sticky (ovf_sticky),
        .drop_cnt   (drop_cnt),
        .flag_clr   (flag_clr)
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
    endtask

    initial begin
        vec[0] = '{SOS_Q_ONE, 24'd1000,   24'd1000,   1'b0};
        vec[1] = '{24'h200000, 24'd3,     24'd2,      1'b0};
        vec[2] = '{24'h200000, 24'hFFFFFD, 24'hFFFFFF, 1'b0};
        vec[3] = '{24'h7FFFFF, 24'h7FFFFF, SOS_SAT_MAX, 1'b1};
        vec[4] = '{24'h7FFFFF, 24'h800000, SOS_SAT_MIN, 1'b1};
        vec[5] = '{SOS_Q_ONE, 24'hFFFFFB, 24'hFFFFFB, 1'b0};
        vec[6] = '{24'hC00000, 24'd100,   24'hFFFF9C, 1'b0};
        vec[7] = '{24'hC00000, 24'h800000, SOS_SAT_MAX, 1'b1};
        vec[8] = '{24'h100000, 24'd2,     24'd1,      1'b0};
        vec[9] = '{24'h100000, 24'hFFFFFE, 24'd0,     1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; gain = SOS_Q_ONE;
        out_ready = 1'b0; flag_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_sat", sat_sticky, 0);
        check("rst_ovf", ovf_sticky, 0);
        check("rst_drop", drop_cnt, 0);

        // gain / round / saturate table, single sample each, empty FIFO
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            pulse_clr();
            gain = vec[i].gain; in_data = vec[i].din; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            check("vec_no_bypass", out_valid, 0);
            tick();
            check("vec_valid", out_valid, 1);
            check("vec_data", out_data, vec[i].exp_out);
            check("vec_sat", sat_sticky, vec[i].exp_sat);
            check("vec_ovf", ovf_sticky, 0);
            tick();
            check("vec_popped", out_valid, 0);
        end

        // overflow: 20 samples into a stalled consumer
        pulse_clr();
        out_ready = 1'b0; gain = SOS_Q_ONE;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            if (i <= 16) exp_q.push_back(W'(i));
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("ovf_level", level, 16);
        check("ovf_drop", drop_cnt, 4);
        check("ovf_sticky", ovf_sticky, 1);
        check("ovf_sat", sat_sticky, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain_valid", out_valid, 1);
            check("ovf_drain_data", out_data, exp_q[0]);
            tick();
            void'(exp_q.pop_front());
        end
        check("ovf_empty", out_valid, 0);
        check("ovf_empty_level", level, 0);

        // full FIFO with simultaneous push and pop
        pulse_clr();
        out_ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_valid = 1'b1; in_data = W'(300 + c);
            exp_q.push_back(W'(300 + c));
            out_ready = (c >= 18);
            if (c >= 18) begin
                check("pp_level", level, 16);
                check("pp_valid", out_valid, 1);
                check("pp_data", out_data, exp_q[0]);
            end
            tick();
            if (c >= 18) void'(exp_q.pop_front());
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() > 0) begin
                check("pp_drain_valid", out_valid, 1);
                check("pp_drain_data", out_data, exp_q[0]);
                tick();
                void'(exp_q.pop_front());
            end else begin
                tick();
            end
        end
        check("pp_empty", out_valid, 0);
        check("pp_drop", drop_cnt, 0);
        check("pp_ovf", ovf_sticky, 0);

        // flag_clr in the same cycle as a drop
        out_ready = 1'b0;
        for (int c = 0; c < 24; c++) begin
            in_valid = (c < 18) || (c == 20);
            in_data  = W'(c + 1);
            flag_clr = (c == 19);
            if (c == 19) begin
                check("clr_pre_drop", drop_cnt, 1);
                check("clr_pre_ovf", ovf_sticky, 1);
            end
            if (c >= 20 && c <= 22) begin
                check("clr_drop", drop_cnt, 0);
                check("clr_ovf", ovf_sticky, 0);
            end
            if (c == 23) begin
                check("clr_next_drop", drop_cnt, 1);
                check("clr_next_ovf", ovf_sticky, 1);
                check("clr_level", level, 16);
            end
            tick();
        end
        in_valid = 1'b0; flag_clr = 1'b0;

        // reset mid-stream: level 5 with two samples still in S1/S2
        out_ready = 1'b1;
        repeat (20) tick();
        check("mr_drained", level, 0);
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1;
            gain     = (c == 0) ? 24'h7FFFFF : SOS_Q_ONE;
            in_data  = (c == 0) ? 24'h7FFFFF : W'(c + 10);
            tick();
        end
        in_valid = 1'b0;
        check("mr_pre_level", level, 5);
        check("mr_pre_sat", sat_sticky, 1);
        check("mr_pre_ovf", ovf_sticky, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_level", level, 0);
        check("mr_valid", out_valid, 0);
        check("mr_data", out_data, 0);
        check("mr_sat", sat_sticky, 0);
        check("mr_ovf", ovf_sticky, 0);
        check("mr_drop", drop_cnt, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("mr_no_stale", out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
